// File: rtl/lfsr_chk_pkg.sv
// Shared definitions for the 8-bit LFSR sequence checker: FSM encoding, polynomial constants
// and the Galois next-state function.
package lfsr_chk_pkg;

  typedef enum logic [1:0] {
    StSearch  = 2'd0,
    StConfirm = 2'd1,
    StLocked  = 2'd2
  } lfsr_state_e;

  // x^8 + x^6 + x^5 + x + 1
  localparam logic [8:0] LFSR_POLY   = 9'h163;
  // Feedback mask XORed into the right-shifted state when the shifted-out bit is 1
  localparam logic [7:0] LFSR_MASK   = 8'hB1;
  localparam logic [7:0] LOCKUP_WORD = 8'h00;

  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    lfsr8_next = {1'b0, s[7:1]} ^ (s[0] ? LFSR_MASK : 8'h00);
  endfunction

endpackage

// File: rtl/lfsr8_step.sv
// Combinational one-step advance of the 8-bit Galois LFSR; shared with the generator side.
module lfsr8_step
  import lfsr_chk_pkg::*;
(
  input  logic [7:0] cur_state,
  output logic [7:0] next_state
);

  assign next_state = lfsr8_next(cur_state);

endmodule

// File: rtl/lfsr_checker_8bit.sv
// Receive-side checker for an 8-bit Galois LFSR stream: acquires lock, flags mismatches.
// Define LFSR_CHK_ERR_CNT_EN to build the saturating error counter (else err_count is 0).
module lfsr_checker_8bit
  import lfsr_chk_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             data_valid,
  input  logic [7:0]       data_in,
  input  logic             clear_count,
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [1:0] ST_SEARCH  = StSearch;
  localparam logic [1:0] ST_CONFIRM = StConfirm;
  localparam logic [1:0] ST_LOCKED  = StLocked;

  logic [1:0] state_q, state_d;
  logic [7:0] pred_q, pred_d;
  logic [3:0] match_q, match_d;
  logic [3:0] miss_q, miss_d;
  logic       locked_q, error_q;
  logic       err_hit;
  logic [7:0] next_in, next_pred;
  logic [3:0] match_inc, miss_inc;

  lfsr8_step u_step_in (
    .cur_state  (data_in),
    .next_state (next_in)
  );

  lfsr8_step u_step_pred (
    .cur_state  (pred_q),
    .next_state (next_pred)
  );

  assign match_inc = match_q + 4'd1;
  assign miss_inc  = miss_q + 4'd1;

  always_comb begin
    state_d = state_q;
    pred_d  = pred_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_hit = 1'b0;
    if (data_valid) begin
      case (state_q)
        ST_SEARCH: begin
          if (data_in != LOCKUP_WORD) begin
            pred_d  = next_in;
            match_d = '0;
            state_d = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (data_in == pred_q) begin
            match_d = match_inc;
            pred_d  = next_in;
            if (match_inc == 4'(LOCK_CNT)) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
              pred_d  = next_pred;
            end
          end else if (data_in != LOCKUP_WORD) begin
            pred_d  = next_in;
            match_d = '0;
          end else begin
            match_d = '0;
            state_d = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          // Free-running predictor: a corrupted beat must not reseed it
          pred_d = next_pred;
          if (data_in == pred_q) begin
            miss_d = '0;
          end else begin
            err_hit = 1'b1;
            if (miss_inc == 4'(LOSS_CNT)) begin
              miss_d  = '0;
              state_d = ST_SEARCH;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_SEARCH;
      pred_q   <= LOCKUP_WORD;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pred_q   <= pred_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= (state_d == ST_LOCKED);
      error_q  <= err_hit;
    end
  end

  assign locked = locked_q;
  assign error  = error_q;

`ifdef LFSR_CHK_ERR_CNT_EN
  logic [ERR_W-1:0] cnt_q, cnt_d;

  // A clear coinciding with a counted error leaves that error counted
  always_comb begin
    cnt_d = cnt_q;
    if (clear_count) begin
      cnt_d = err_hit ? ERR_W'(1) : '0;
    end else if (err_hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_count = cnt_q;
`else
  logic unused_clear;
  assign unused_clear = clear_count;
  assign err_count    = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker_8bit.sv
// Directed bench for lfsr_checker_8bit; a second instance with a 3-bit counter covers saturation.
module tb_lfsr_checker_8bit;

`ifdef LFSR_CHK_ERR_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       clear_count = 1'b0;
  logic       locked, error;
  logic [15:0] err_count;
  logic       locked_s, error_s;
  logic [2:0] err_count_s;

  int total = 0;
  int bad = 0;
  int n_err;
  logic [7:0] cur;

  always #5 clock = ~clock;

  lfsr_checker_8bit dut (
    .clock       (clock),
    .reset       (reset),
    .data_valid  (data_valid),
    .data_in     (data_in),
    .clear_count (clear_count),
    .locked      (locked),
    .error       (error),
    .err_count   (err_count)
  );

  lfsr_checker_8bit #(.ERR_W(3)) dut_sat (
    .clock       (clock),
    .reset       (reset),
    .data_valid  (data_valid),
    .data_in     (data_in),
    .clear_count (clear_count),
    .locked      (locked_s),
    .error       (error_s),
    .err_count   (err_count_s)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ecnt(input int n);
    return CntEn ? n : 0;
  endfunction

  function automatic int ecnt_sat(input int n);
    return CntEn ? ((n > 7) ? 7 : n) : 0;
  endfunction

  // Stream generator for long runs (mask form: shift right, XOR 0xB1 when bit 0 falls out)
  function automatic logic [7:0] tb_next(input logic [7:0] s);
    return s[0] ? ({1'b0, s[7:1]} ^ 8'hB1) : {1'b0, s[7:1]};
  endfunction

  task automatic beat(input logic v, input logic [7:0] d, input logic clr);
    @(negedge clock);
    data_valid  = v;
    data_in     = d;
    clear_count = clr;
    @(posedge clock);
    #1;
    data_valid  = 1'b0;
    clear_count = 1'b0;
  endtask

  task automatic clean_beat(input logic clr);
    beat(1'b1, cur, clr);
    cur = tb_next(cur);
  endtask

  task automatic wrong_beat(input logic clr);
    beat(1'b1, ~cur, clr);
    cur = tb_next(cur);
  endtask

  // Hand-computed: reseed mid-CONFIRM, zero beats back to SEARCH, then relock from 0x01
  logic [7:0] vec [20] = '{8'h01, 8'hB1, 8'hE9, 8'h5A, 8'h2D, 8'hA7, 8'hE2,
                           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                           8'h01, 8'hB1, 8'hE9, 8'hC5, 8'hD3};

  initial begin
    #2;
    check("rst_locked", locked, 0);
    check("rst_error", error, 0);
    check("rst_count", err_count, 0);
    @(negedge clock);
    reset = 1'b1;

    // Clean acquisition from seed 0x01
    cur = 8'h01;
    for (int i = 1; i <= 10; i++) begin
      clean_beat(1'b0);
      check($sformatf("acq_locked_%0d", i), locked, (i >= 5) ? 1 : 0);
      check($sformatf("acq_error_%0d", i), error, 0);
    end
    check("acq_count", err_count, 0);

    // Single corrupted beat while locked
    wrong_beat(1'b0);
    check("one_err_pulse", error, 1);
    check("one_err_locked", locked, 1);
    check("one_err_count", err_count, ecnt(1));
    clean_beat(1'b0);
    check("one_err_recover", error, 0);
    check("one_err_still_locked", locked, 1);
    check("one_err_count_hold", err_count, ecnt(1));
    beat(1'b0, 8'h00, 1'b0);
    check("gap_error", error, 0);
    check("gap_locked", locked, 1);

    // Three consecutive misses drop lock
    for (int k = 1; k <= 3; k++) begin
      wrong_beat(1'b0);
      check($sformatf("loss_err_%0d", k), error, 1);
      check($sformatf("loss_locked_%0d", k), locked, (k < 3) ? 1 : 0);
      check($sformatf("loss_count_%0d", k), err_count, ecnt(1 + k));
    end
    for (int i = 1; i <= 5; i++) begin
      clean_beat(1'b0);
      check($sformatf("relock_%0d", i), locked, (i == 5) ? 1 : 0);
      check($sformatf("relock_err_%0d", i), error, 0);
    end
    check("relock_count", err_count, ecnt(4));

    // Clear interacting with a counted error
    wrong_beat(1'b0);
    check("pre_clr_count", err_count, ecnt(5));
    clean_beat(1'b0);
    wrong_beat(1'b1);
    check("clr_with_err_count", err_count, ecnt(1));
    check("clr_with_err_pulse", error, 1);
    clean_beat(1'b1);
    check("clr_alone_count", err_count, 0);
    check("clr_alone_locked", locked, 1);
    beat(1'b0, 8'h00, 1'b0);
    check("gap2_error", error, 0);

    // Asynchronous reset while locked with an error pulse showing
    wrong_beat(1'b0);
    check("pre_rst_error", error, 1);
    reset = 1'b0;
    #1;
    check("async_rst_locked", locked, 0);
    check("async_rst_error", error, 0);
    check("async_rst_count", err_count, 0);
    check("async_rst_sat_locked", locked_s, 0);
    @(negedge clock);
    data_valid = 1'b1;
    data_in    = cur;
    @(posedge clock);
    #1;
    check("rst_hold_locked", locked, 0);
    @(negedge clock);
    data_valid = 1'b0;
    reset      = 1'b1;

    // Directed hand-computed vectors
    for (int i = 0; i < 20; i++) begin
      beat(1'b1, vec[i], 1'b0);
      check($sformatf("vec_locked_%0d", i), locked, (i == 19) ? 1 : 0);
      check($sformatf("vec_error_%0d", i), error, 0);
    end
    check("vec_count", err_count, 0);
    cur = tb_next(8'hD3);

    // Saturation: two misses then a match, repeated, keeps lock while counting
    n_err = 0;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 2; k++) begin
        wrong_beat(1'b0);
        n_err++;
        check($sformatf("sat_count_%0d", n_err), err_count, ecnt(n_err));
        check($sformatf("sat_small_%0d", n_err), err_count_s, ecnt_sat(n_err));
      end
      clean_beat(1'b0);
      check($sformatf("sat_locked_%0d", r), locked, 1);
      check($sformatf("sat_small_locked_%0d", r), locked_s, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_checker_8bit.md
LFSR_CHECKER_8BIT -- requirements
Module: lfsr_checker_8bit

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4: consecutive predicted matches in CONFIRM required to declare lock (range 1..15).
REQ-002 SHALL have parameter LOSS_CNT, default 3: consecutive mismatches in LOCKED that drop lock (range 1..15).
REQ-003 SHALL have parameter ERR_W, default 16: error counter width.
REQ-004 SHALL have port clock, input, 1: clock, rising edge.
REQ-005 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port data_valid, input, 1: data_in carries one LFSR state this cycle.
REQ-007 SHALL have port data_in, input, 8: received LFSR state word.
REQ-008 SHALL have port clear_count, input, 1: synchronous clear of err_count.
REQ-009 SHALL have port locked, output, 1: checker is synchronised to the sequence.
REQ-010 SHALL have port error, output, 1: one-cycle pulse per mismatched beat while locked.
REQ-011 SHALL have port err_count, output, ERR_W: saturating count of locked-state mismatches.

Function
REQ-012 SHALL use the Galois next-state function N(s) for polynomial x^8+x^6+x^5+x+1: N = {s0, s7, s6^s0, s5^s0, s4, s3, s2, s1^s0}, MSB first (e.g. N(0x01)=0xB1, N(0xB1)=0xE9).
REQ-013 SHALL implement FSM states SEARCH, CONFIRM, LOCKED; only beats with data_valid=1 advance state, counters or the predictor.
REQ-014 SEARCH: valid nonzero data_in -> pred=N(data_in), match_cnt=0, go CONFIRM; valid 0x00 (lock-up word) -> stay SEARCH.
REQ-015 CONFIRM: data_in==pred -> match_cnt+1, pred=N(data_in); when the incremented match_cnt equals LOCK_CNT, go LOCKED with miss_cnt=0 and pred=N(pred).
REQ-016 CONFIRM: mismatch with nonzero data_in -> reseed pred=N(data_in), match_cnt=0, stay CONFIRM; mismatch with 0x00 -> go SEARCH.
REQ-017 LOCKED: the predictor SHALL free-run from its own value (pred=N(pred) every valid beat) and never reload from data_in.
REQ-018 LOCKED: match -> miss_cnt=0; mismatch -> error pulse, err_count increment, miss_cnt+1; when miss_cnt reaches LOSS_CNT, go SEARCH.
REQ-019 locked SHALL be 1 exactly in state LOCKED; locked and error SHALL be registered, changing in the cycle after the deciding valid beat.
REQ-020 Mismatches in SEARCH and CONFIRM SHALL NOT pulse error or change err_count.
REQ-021 err_count SHALL saturate at all-ones and not wrap.
REQ-022 clear_count with a simultaneous counted error SHALL yield err_count=1; clear_count alone yields 0.
REQ-023 data_valid=0 cycles SHALL hold all state; error SHALL be 0 in those cycles.

Reset
REQ-024 reset low SHALL asynchronously force state=SEARCH, pred=0x00, match_cnt=0, miss_cnt=0, locked=0, error=0, err_count=0.
REQ-025 Reset asserted mid-sequence SHALL discard lock; after release, resynchronisation SHALL start from the next valid beat per REQ-014.

Configuration
REQ-026 Macro LFSR_CHK_ERR_CNT_EN defined: err_count and clear_count SHALL behave per REQ-021/022.
REQ-027 Macro LFSR_CHK_ERR_CNT_EN undefined: no counter flops; err_count SHALL be constant 0; clear_count ignored; the port list SHALL be unchanged.

Structure
REQ-028 Package lfsr_chk_pkg SHALL hold the FSM state enum, the polynomial constant, the lock-up word constant 0x00, and function lfsr8_next implementing N.
REQ-029 A combinational sub-module lfsr8_step (in 8, out 8, computes N) SHALL be the one sub-module, reusable by the generator side.

Verification
REQ-030 Seed 0x01, 10 valid beats of a clean sequence (0x01,0xB1,0xE9,...) -> locked=1 the cycle after beat 5 (seed + 4 matches), error never 1, err_count=0.
REQ-031 Locked; one beat corrupted (expected 0xE9 driven as 0xE8) -> single error pulse, err_count=1, locked stays 1, next clean beat matches.
REQ-032 Locked; 3 consecutive wrong beats -> 3 error pulses, err_count=3, locked=0 after third; a clean stream relocks after 5 beats.
REQ-033 SEARCH with data_in=0x00 for 8 beats, then 0x01 -> stays SEARCH during zeros, enters CONFIRM on 0x01.
REQ-034 Locked, err_count=5, clear_count and a mismatch in the same cycle -> err_count=1; err_count forced near all-ones plus 2 errors -> holds 0xFFFF.
REQ-035 Reset pulsed while locked with gaps in data_valid -> all outputs 0 immediately; with LFSR_CHK_ERR_CNT_EN undefined, err_count=0 throughout REQ-031.
